// File: rtl/apb_mon_pkg.sv
// Shared types and helpers for the APB protocol monitor.
// Holds the phase FSM states, the violation codes and the lowest-code encoder.
package apb_mon_pkg;

    localparam int ERR_W    = 3;
    localparam int STICKY_W = 8;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        IDLE   = 2'd1,
        SETUP  = 2'd2,
        ACCESS = 2'd3
    } mon_state_e;

    typedef enum logic [ERR_W-1:0] {
        E_NONE        = 3'd0,
        E_MULTI_SEL   = 3'd1,
        E_EN_NO_SETUP = 3'd2,
        E_NO_ENABLE   = 3'd3,
        E_UNSTABLE    = 3'd4,
        E_ABORT       = 3'd5,
        E_TIMEOUT     = 3'd6,
        E_STRB_READ   = 3'd7
    } err_code_e;

    // Lowest-numbered violation wins when several fire in one cycle.
    function automatic logic [ERR_W-1:0] lowest_err(input logic [STICKY_W-1:0] vec);
        logic [ERR_W-1:0] code;
        code = E_NONE;
        for (int i = STICKY_W - 1; i >= 1; i--) begin
            if (vec[i]) code = ERR_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the count at one.
module apb_mon_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB3/APB4 monitor: phase tracking, protocol checks, transfer capture
// and saturating statistics. Every output is registered.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int PADDR_SIZE = 32,
    parameter int PDATA_SIZE = 32,
    parameter int NUM_SEL    = 1,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic [NUM_SEL-1:0]          PSEL,
    input  logic                        PENABLE,
    input  logic [PADDR_SIZE-1:0]       PADDR,
    input  logic                        PWRITE,
    input  logic [PDATA_SIZE/8-1:0]     PSTRB,
    input  logic [PDATA_SIZE-1:0]       PWDATA,
    input  logic [PDATA_SIZE-1:0]       PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR,
    output logic                        mon_valid,
    output logic [$clog2(NUM_SEL):0]    mon_sel,
    output logic [PADDR_SIZE-1:0]       mon_addr,
    output logic                        mon_write,
    output logic [PDATA_SIZE/8-1:0]     mon_strb,
    output logic [PDATA_SIZE-1:0]       mon_data,
    output logic                        mon_slverr,
    output logic [CNT_W-1:0]            mon_waits,
    output logic                        err_valid,
    output logic [ERR_W-1:0]            err_code,
    output logic [STICKY_W-1:0]         err_sticky,
    output logic [CNT_W-1:0]            xfer_cnt,
    output logic [CNT_W-1:0]            err_cnt,
    output logic [CNT_W-1:0]            slverr_cnt,
    output logic [CNT_W-1:0]            wait_max
);

    localparam int STRB_W = PDATA_SIZE / 8;
    localparam int SEL_W  = $clog2(NUM_SEL) + 1;

    mon_state_e              r_state;
    mon_state_e              w_next;
    logic [NUM_SEL-1:0]      r_psel;
    logic [SEL_W-1:0]        r_sel_idx;
    logic [SEL_W-1:0]        w_sel_idx;
    logic [PADDR_SIZE-1:0]   r_addr;
    logic                    r_write;
    logic [STRB_W-1:0]       r_strb;
    logic [PDATA_SIZE-1:0]   r_wdata;
    logic                    r_timeout_seen;
    logic [CNT_W-1:0]        w_waits;
    logic                    w_sel_any;
    logic                    w_multi;
    logic                    w_new_setup;
    logic                    w_unstable;
    logic                    w_capture;
    logic                    w_access;
    logic                    w_complete;
    logic                    w_wait_inc;
    logic [STICKY_W-1:0]     w_err;

    always_comb begin
        w_sel_idx = '0;
        for (int i = NUM_SEL - 1; i >= 0; i--) begin
            if (PSEL[i]) w_sel_idx = SEL_W'(i);
        end
    end

    assign w_sel_any   = |PSEL;
    assign w_multi     = (PSEL & (PSEL - NUM_SEL'(1))) != '0;
    assign w_new_setup = w_sel_any && !PENABLE;
    assign w_unstable  = (PSEL != r_psel) || (PADDR != r_addr) || (PWRITE != r_write) ||
                         (PSTRB != r_strb) || (r_write && (PWDATA != r_wdata));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    // A SETUP cycle followed by a valid enable is already the first access
    // cycle, so it shares the ACCESS checks; zero-wait transfers complete there.
    always_comb begin
        w_next     = r_state;
        w_err      = '0;
        w_capture  = 1'b0;
        w_access   = 1'b0;
        w_complete = 1'b0;
        w_wait_inc = 1'b0;
        case (r_state)
            SYNC: begin
                if (!PENABLE) w_next = IDLE;
            end
            IDLE: begin
                if (PENABLE) begin
                    w_err[E_EN_NO_SETUP] = 1'b1;
                end else if (w_sel_any) begin
                    w_capture = 1'b1;
                    w_next    = SETUP;
                end
            end
            SETUP: begin
                if (PENABLE && (PSEL == r_psel)) begin
                    w_access = 1'b1;
                end else begin
                    w_err[E_NO_ENABLE] = 1'b1;
                    w_capture          = w_new_setup;
                    w_next             = w_new_setup ? SETUP : IDLE;
                end
            end
            ACCESS: begin
                if ((!PENABLE || !w_sel_any) && !PREADY) begin
                    w_err[E_ABORT] = 1'b1;
                    w_capture      = w_new_setup;
                    w_next         = w_new_setup ? SETUP : IDLE;
                end else begin
                    w_access = 1'b1;
                end
            end
            default: w_next = SYNC;
        endcase

        if (w_access) begin
            if (w_unstable) w_err[E_UNSTABLE] = 1'b1;
            if (PREADY) begin
                w_complete = 1'b1;
                w_next     = IDLE;
            end else begin
                w_wait_inc = 1'b1;
                w_next     = ACCESS;
                if (!r_timeout_seen && (32'(w_waits) == 32'(TIMEOUT - 1))) begin
                    w_err[E_TIMEOUT] = 1'b1;
                end
            end
        end

        if (w_capture && !PWRITE && (PSTRB != '0)) w_err[E_STRB_READ] = 1'b1;
        if ((r_state != SYNC) && w_multi) w_err[E_MULTI_SEL] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_psel         <= '0;
            r_sel_idx      <= '0;
            r_addr         <= '0;
            r_write        <= 1'b0;
            r_strb         <= '0;
            r_wdata        <= '0;
            r_timeout_seen <= 1'b0;
        end else begin
            if (w_capture) begin
                r_psel    <= PSEL;
                r_sel_idx <= w_sel_idx;
                r_addr    <= PADDR;
                r_write   <= PWRITE;
                r_strb    <= PSTRB;
                r_wdata   <= PWDATA;
            end
            if (w_capture) begin
                r_timeout_seen <= 1'b0;
            end else if (w_err[E_TIMEOUT]) begin
                r_timeout_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mon_valid  <= 1'b0;
            mon_sel    <= '0;
            mon_addr   <= '0;
            mon_write  <= 1'b0;
            mon_strb   <= '0;
            mon_data   <= '0;
            mon_slverr <= 1'b0;
            mon_waits  <= '0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_sticky <= '0;
            wait_max   <= '0;
        end else begin
            mon_valid <= w_complete;
            if (w_complete) begin
                mon_sel    <= r_sel_idx;
                mon_addr   <= r_addr;
                mon_write  <= r_write;
                mon_strb   <= r_strb;
                mon_data   <= r_write ? PWDATA : PRDATA;
                mon_slverr <= PSLVERR;
                mon_waits  <= w_waits;
            end
            err_valid  <= |w_err;
            err_code   <= lowest_err(w_err);
            err_sticky <= (clr ? '0 : err_sticky) | w_err;
            if (clr) begin
                wait_max <= w_complete ? w_waits : '0;
            end else if (w_complete && (w_waits > wait_max)) begin
                wait_max <= w_waits;
            end
        end
    end

    apb_mon_sat_cnt #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (w_wait_inc),
        .clr   (w_capture),
        .count (w_waits)
    );

    apb_mon_sat_cnt #(.W(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (w_complete),
        .clr   (clr),
        .count (xfer_cnt)
    );

    apb_mon_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (|w_err),
        .clr   (clr),
        .count (err_cnt)
    );

    apb_mon_sat_cnt #(.W(CNT_W)) u_slverr_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (w_complete && PSLVERR),
        .clr   (clr),
        .count (slverr_cnt)
    );

endmodule

// File: doc/apb_protocol_monitor.md
Name: apb_protocol_monitor

Overview:
Synthesizable APB3/APB4 bus monitor and protocol checker that sits passively beside an APB bus in the GPIO testbench and SoC-level harness. It tracks every transfer with a phase FSM, checks the protocol rules on multi-slave select lines, and flags violations with a coded, registered error pulse plus sticky flags. Each completed transfer is published on a registered capture port, and transfer, error and wait-state statistics are accumulated.

Parameters:
PADDR_SIZE, 32, address width
PDATA_SIZE, 32, data width; PSTRB width is PDATA_SIZE/8
NUM_SEL, 1, number of PSEL lines (slaves) monitored, 1..16
TIMEOUT, 16, wait-state count (PREADY low in ACCESS) that raises E_TIMEOUT, >=1
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  bus clock
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of counters and sticky flags
PSEL  in  NUM_SEL  slave selects
PENABLE  in  1  access phase
PADDR  in  PADDR_SIZE  address
PWRITE  in  1  direction
PSTRB  in  PDATA_SIZE/8  write strobes
PWDATA  in  PDATA_SIZE  write data
PRDATA  in  PDATA_SIZE  read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error
mon_valid  out  1  one-cycle pulse: completed transfer captured
mon_sel  out  $clog2(NUM_SEL)+1  index of selected slave
mon_addr  out  PADDR_SIZE  / mon_write out 1 / mon_strb out PDATA_SIZE/8  captured setup-phase values
mon_data  out  PDATA_SIZE  PWDATA (write) or PRDATA (read)
mon_slverr  out  1  PSLVERR at completion
mon_waits  out  CNT_W  wait states of this transfer
err_valid  out  1  one-cycle pulse: violation detected
err_code  out  3  lowest-numbered violation of that cycle
err_sticky  out  8  bit n set when code n has been seen
xfer_cnt, err_cnt, slverr_cnt, wait_max  out  CNT_W each  statistics, saturating

Behaviour:
- Reset: all outputs 0, FSM in SYNC. Entered asynchronously at any time, including mid-transfer.
- Latency: all outputs are registered. Violations and captures appear the cycle after the clk edge on which they were sampled.
- FSM states: SYNC, IDLE, SETUP, ACCESS.
- SYNC: no checks are made. Go to IDLE on the first sample with PENABLE=0. This prevents false errors when reset releases mid-transfer.
- Any state: popcount(PSEL)>1 raises E_MULTI_SEL(1).
- IDLE:
  - PSEL!=0 and !PENABLE: go to SETUP and capture PADDR, PWRITE, PSTRB, PWDATA and the select index.
  - PENABLE=1 raises E_EN_NO_SETUP(2) and the state stays IDLE.
- SETUP:
  - Same PSEL and PENABLE=1: go to ACCESS.
  - Otherwise raise E_NO_ENABLE(3). If PSEL!=0 and !PENABLE, restart SETUP with a new capture; else go to IDLE.
- ACCESS, every cycle:
  - PSEL, PADDR, PWRITE and PSTRB must equal the captured values, and PWDATA too when writing. A mismatch raises E_UNSTABLE(4).
  - Reads with PSTRB!=0 raise E_STRB_READ(7); this is checked once, at SETUP entry.
- ACCESS, PENABLE=0 or PSEL dropped while PREADY=0: raise E_ABORT(5). Go to IDLE, or to SETUP if a new setup is present. No capture.
- ACCESS, PREADY=0: increment the wait counter, saturating. At wait==TIMEOUT raise E_TIMEOUT(6) exactly once per transfer and stay in ACCESS.
- ACCESS, PREADY=1: complete the transfer.
  - Pulse mon_valid with mon_data = PWDATA (write) or PRDATA (read), mon_slverr = PSLVERR, mon_waits = wait count.
  - Increment xfer_cnt. Increment slverr_cnt if PSLVERR. wait_max = max(wait_max, waits).
  - Go to IDLE, so back-to-back transfers enter SETUP next cycle with no gap penalty.
- Error reporting:
  - Several violations in one cycle: err_code is the lowest code, err_sticky ORs all of them, err_cnt increments by 1.
- Counters:
  - Saturate at 2^CNT_W-1 and never wrap.
  - clr zeroes the counters and err_sticky. When an event lands in the same cycle as clr, the clear applies first, then the event (result 1 or the new bit).
- PSLVERR outside a completion is ignored.

Decomposition:
- Package apb_mon_pkg holds:
  - the state enum (SYNC, IDLE, SETUP, ACCESS);
  - the err_code enum (E_NONE=0 .. E_STRB_READ=7);
  - the err_code width constant of 3 and the sticky width constant of 8.
- Sub-module apb_mon_sat_cnt (parameter W; inputs inc, clr; output count) is instantiated for every statistics counter and for the wait counter.

Test Plan:
- Write to PADDR=0x10, PWDATA=0xA5A5_0001, PSTRB=0xF, 0 waits -> mon_valid one cycle after the PREADY edge, mon_write=1, mon_data=0xA5A5_0001, xfer_cnt=1, no err_valid.
- Read with 3 waits, PRDATA=0x1234, PSLVERR=1 -> mon_waits=3, mon_slverr=1, slverr_cnt=1, wait_max=3.
- TIMEOUT=4 with 6 waits -> single err_valid, err_code=6 after the 4th wait cycle; transfer still captured with mon_waits=6.
- PADDR changed during ACCESS while PSTRB!=0 on a read -> err_code=7 at setup entry, then err_code=4. err_sticky=0x90, err_cnt=2.
- PSEL=2'b11 plus PENABLE in IDLE -> err_code=1 (lowest), err_sticky bits 1 and 2 set. clr in the same cycle still yields err_cnt=1.
- rst asserted mid-ACCESS and released with PENABLE=1 held 2 cycles -> outputs 0, no errors until PENABLE=0. The next clean transfer gives xfer_cnt=1.
